// File: rtl/zero_rle_pkg.sv
// Shared definitions for the zero run-length link.
// Used by both the producer (zero_detect) and the consumer (zero_rle_expander).
//  - DEFAULT_DATA_W : default literal / run-length field width
//  - token_t        : token bit layout {is_run, data}
//  - state_e        : expander state encoding (IDLE=1'b0, RUN=1'b1)
package zero_rle_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Token layout on the link: MSB flags a run, the rest is either the
    // literal byte or (run length - 1).
    localparam int TOKEN_W          = DEFAULT_DATA_W + 1;
    localparam int TOKEN_IS_RUN_BIT = DEFAULT_DATA_W;

    typedef struct packed {
        logic                      is_run;
        logic [DEFAULT_DATA_W-1:0] data;
    } token_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic token_t make_token(input logic is_run,
                                          input logic [DEFAULT_DATA_W-1:0] data);
        token_t t;
        t.is_run = is_run;
        t.data   = data;
        return t;
    endfunction

endpackage

// File: rtl/zero_rle_expander.sv
// Expands a zero-run-length token stream back into a byte stream.
// A literal token produces one byte; a run token with in_data = L-1 produces
// L zero bytes (1..2^DATA_W). One registered output stage, one byte per cycle.
// Ports:
//  clk, rst   : clock, asynchronous active-high reset
//  in_valid / in_ready / in_is_run / in_data : token input (valid/ready)
//  out_valid / out_ready / out_data          : byte output (valid/ready)
//  busy       : high while a run is being expanded (state RUN)
module zero_rle_expander #(
    parameter int DATA_W = zero_rle_pkg::DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_run,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    import zero_rle_pkg::*;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    // Zeros still to be emitted after the one currently on the output.
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              accept;

    // Accept only when idle and the output register is free or being drained
    // this cycle. Held low during reset so no token is taken while the state
    // is being cleared.
    assign in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    if (in_is_run) begin
                        // First zero of the run goes out right away; rem
                        // counts the zeros that follow it.
                        out_data_d = '0;
                        rem_d      = in_data;
                        if (in_data != '0) begin
                            state_d = RUN;
                        end
                    end else begin
                        out_data_d = in_data;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            RUN: begin
                // Output stays a valid zero; each consumed beat re-presents
                // the next zero until the counter is used up.
                if (out_ready) begin
                    if (rem_q == DATA_W'(1)) begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - DATA_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rem_q       <= rem_d;
        end
    end

endmodule

// File: tb/tb_zero_rle_expander.sv
// Self-checking bench for zero_rle_expander.
// Model: a queue of bytes still owed to the output. Every accepted token
// appends its expansion (1 literal or L zeros); every consumed beat pops the
// head. From that queue the bench derives out_valid, out_data, in_ready and
// busy each cycle, and directed tests pin the model with literal expectations.
module tb_zero_rle_expander;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_is_run;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    zero_rle_expander #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_is_run (in_is_run),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] got_q[$];

    // Handshake snapshot taken at the falling edge, applied at the next rise.
    logic       acc_s     = 1'b0;
    logic       pop_s     = 1'b0;
    logic       is_run_s  = 1'b0;
    logic [7:0] data_s    = 8'h00;
    logic [7:0] outdata_s = 8'h00;

    int cyc           = 0;
    int first_acc_cyc = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;
    int cnt_notready  = 0;
    int cnt_busy      = 0;
    logic count_en    = 1'b0;

    logic [7:0] exp2[4] = '{8'h01, 8'hAA, 8'h10, 8'hFF};
    logic [7:0] exp3[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55};

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison against the owed-bytes queue.
    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        chk("out_valid", int'(out_valid), int'(sz != 0));
        if (sz != 0) chk("out_data", int'(out_data), int'(model_q[0]));
        chk("in_ready", int'(in_ready),
            int'(!rst && (sz == 0 || (sz == 1 && out_ready))));
        chk("busy", int'(busy), int'(sz >= 2));
        if (count_en) begin
            if (!in_ready) cnt_notready++;
            if (busy) cnt_busy++;
        end
        acc_s     = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        is_run_s  = in_is_run;
        data_s    = in_data;
        outdata_s = out_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            acc_s = 1'b0;
            pop_s = 1'b0;
        end else begin
            cyc++;
            if (pop_s && model_q.size() != 0) begin
                if (got_q.size() == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                got_q.push_back(outdata_s);
                void'(model_q.pop_front());
            end
            if (acc_s) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (is_run_s) begin
                    for (int k = 0; k <= int'(data_s); k++) model_q.push_back(8'h00);
                end else begin
                    model_q.push_back(data_s);
                end
            end
        end
    end

    task automatic clear_log();
        got_q.delete();
        first_acc_cyc = -1;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
        cnt_notready  = 0;
        cnt_busy      = 0;
    endtask

    // Present a token and hold it until accepted; returns just after the
    // accepting edge.
    task automatic send(input logic r, input logic [7:0] d);
        int n;
        in_valid  = 1'b1;
        in_is_run = r;
        in_data   = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_valid || model_q.size() != 0) && n < 2000) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (out_valid) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_is_run = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", int'(in_ready), 1);

        // Test 1: async reset mid-stream
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        chk("t1_valid_before", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_valid_async", int'(out_valid), 0);
        chk("t1_busy_async", int'(busy), 0);
        chk("t1_ready_async", int'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t1_ready_release", int'(in_ready), 1);
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        chk("t1_no_beats", got_q.size(), 0);
        chk("t1_valid_idle", int'(out_valid), 0);

        // Test 2: back-to-back literals
        clear_log();
        send(1'b0, 8'h01);
        send(1'b0, 8'hAA);
        send(1'b0, 8'h10);
        send(1'b0, 8'hFF);
        drain();
        chk("t2_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t2_byte", int'(got_q[i]), int'(exp2[i]));
        chk("t2_latency", first_pop_cyc - first_acc_cyc, 1);
        chk("t2_consecutive", last_pop_cyc - first_pop_cyc, 3);

        // Test 3: run of 4 then literal
        clear_log();
        count_en = 1'b1;
        send(1'b1, 8'h03);
        send(1'b0, 8'h55);
        drain();
        count_en = 1'b0;
        chk("t3_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t3_byte", int'(got_q[i]), int'(exp3[i]));
        chk("t3_notready_cycles", cnt_notready, 3);
        chk("t3_busy_cycles", cnt_busy, 3);

        // Test 4: run of 1 then run of 256
        clear_log();
        count_en = 1'b1;
        send(1'b1, 8'h00);
        chk("t4_busy_between", int'(busy), 0);
        send(1'b1, 8'hFF);
        drain();
        count_en = 1'b0;
        chk("t4_count", got_q.size(), 257);
        begin
            int nz;
            nz = 0;
            foreach (got_q[i]) if (got_q[i] != 8'h00) nz++;
            chk("t4_all_zero", nz, 0);
        end
        chk("t4_no_gap", last_pop_cyc - first_pop_cyc, 256);
        chk("t4_busy_cycles", cnt_busy, 255);

        // Test 5: run of 5 under toggling out_ready
        clear_log();
        begin
            logic [7:0] pat;
            pat = 8'b11011001;  // applied LSB first: 1,0,0,1,1,0,1,1
            send(1'b1, 8'h04);
            for (int i = 0; i < 8; i++) begin
                out_ready = pat[i];
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
        end
        chk("t5_valid_after", int'(out_valid), 0);
        chk("t5_count", got_q.size(), 5);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_extra", got_q.size(), 5);

        // Test 6: reset after 2 of 6 run zeros
        clear_log();
        send(1'b1, 8'h05);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("t6_two_beats", got_q.size(), 2);
        chk("t6_busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy_async", int'(busy), 0);
        chk("t6_valid_async", int'(out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_residual", int'(out_valid), 0);
        send(1'b0, 8'h7E);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("t6_count", got_q.size(), 1);
        if (got_q.size() != 0) chk("t6_byte", int'(got_q[0]), 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
